// File: rtl/led_sequencer.sv
// led_sequencer: LED pattern sequencer with programmable prescaler.
// Patterns: WALK, BOUNCE, FILL, BLINK. Optional global PWM dimmer is
// enabled by defining LED_SEQ_PWM_EN (adds the duty port and pwm counter).
module led_sequencer #(
    parameter int N_LEDS   = 4,
    parameter int TICK_DIV = 25000000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                dir,
`ifdef LED_SEQ_PWM_EN
    input  logic [PWM_BITS-1:0] duty,
`endif
    output logic [N_LEDS-1:0]   leds,
    output logic                step
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(N_LEDS);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(N_LEDS - 1);

    typedef enum logic [1:0] {
        M_WALK   = 2'b00,
        M_BOUNCE = 2'b01,
        M_FILL   = 2'b10,
        M_BLINK  = 2'b11
    } mode_t;

    if (N_LEDS < 2 || TICK_DIV < 1 || PWM_BITS < 1) begin : g_bad_params
        $error("led_sequencer: illegal parameter values");
    end

    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_pos;
    logic              r_up;
    logic              r_phase;
    mode_t             r_mode;
    logic [N_LEDS-1:0] r_leds;
    logic              r_step;

    logic              w_mode_chg;
    logic              w_tick;
    logic [CW-1:0]     w_cnt_nxt;
    logic [PW-1:0]     w_pos_nxt;
    logic              w_up_nxt;
    logic              w_phase_nxt;
    mode_t             w_mode_nxt;
    logic [N_LEDS-1:0] w_pat;
    logic              w_gate;

    // Next-state of the pattern engine, assuming the cycle is enabled.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_mode_chg  = (mode_t'(mode) != r_mode);
        w_tick      = (r_cnt == CNT_LAST) && !w_mode_chg;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        w_up_nxt    = r_up;
        w_phase_nxt = r_phase;
        w_mode_nxt  = r_mode;
        if (w_mode_chg) begin
            w_mode_nxt  = mode_t'(mode);
            w_cnt_nxt   = '0;
            w_pos_nxt   = '0;
            w_up_nxt    = 1'b1;
            w_phase_nxt = 1'b0;
        end else begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
            if (w_tick) begin
                case (r_mode)
                    M_WALK: begin
                        if (!dir) w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);
                        else      w_pos_nxt = (r_pos == '0) ? POS_LAST : r_pos - PW'(1);
                    end
                    M_BOUNCE: begin
                        if (r_up && r_pos == POS_LAST) begin
                            w_up_nxt  = 1'b0;
                            w_pos_nxt = POS_LAST - PW'(1);
                        end else if (!r_up && r_pos == '0) begin
                            w_up_nxt  = 1'b1;
                            w_pos_nxt = PW'(1);
                        end else begin
                            w_pos_nxt = r_up ? r_pos + PW'(1) : r_pos - PW'(1);
                        end
                    end
                    M_FILL:  w_pos_nxt   = (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);
                    default: w_phase_nxt = ~r_phase;
                endcase
            end
        end
    end

    // Decode the LED pattern from the next-state values.
    always_comb begin
        w_pat = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            case (w_mode_nxt)
                M_WALK, M_BOUNCE: w_pat[i] = (PW'(i) == w_pos_nxt);
                M_FILL:  w_pat[i] = dir ? (PW'(N_LEDS - 1 - i) <= w_pos_nxt)
                                        : (PW'(i) <= w_pos_nxt);
                default: w_pat[i] = w_phase_nxt;
            endcase
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [PWM_BITS-1:0] r_pwm;

    // Free-running dimmer counter, frozen while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   r_pwm <= '0;
        else if (en) r_pwm <= r_pwm + PWM_BITS'(1);
    end

    assign w_gate = (r_pwm < duty) | (&duty);
`else
    assign w_gate = 1'b1;
`endif

    // State and registered outputs; disabled cycles hold state and blank LEDs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_pos   <= '0;
            r_up    <= 1'b1;
            r_phase <= 1'b0;
            r_mode  <= M_WALK;
            r_leds  <= '0;
            r_step  <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
            r_up    <= w_up_nxt;
            r_phase <= w_phase_nxt;
            r_mode  <= w_mode_nxt;
            r_leds  <= w_pat & {N_LEDS{w_gate}};
            r_step  <= w_tick;
        end else begin
            r_leds  <= '0;
            r_step  <= 1'b0;
        end
    end

    assign leds = r_leds;
    assign step = r_step;

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer for board status/indicator LEDs. It drives N_LEDS outputs from a programmable prescaler, with four selectable patterns: walking dot, bounce, bar-fill and blink-all. It also supports direction control, a freeze/blank enable and an optional global PWM dimmer. It sits directly behind the top-level LED pins and replaces fixed 4-LED walkers.

## Interface
- N_LEDS, 4, number of LED outputs; legal range ≥ 2.
- TICK_DIV, 25000000, clocks per pattern step; legal range ≥ 1.
- PWM_BITS, 4, width of the dimmer counter and `duty`; used only with LED_SEQ_PWM_EN.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  reset; asynchronous, active-high.
- en  in  1  1 = run; 0 = freeze all state and blank the LEDs.
- mode  in  2  pattern select: 00 WALK, 01 BOUNCE, 10 FILL, 11 BLINK.
- dir  in  1  WALK/FILL direction: 0 = up (toward bit N_LEDS-1), 1 = down.
- duty  in  PWM_BITS  brightness; this port exists only with LED_SEQ_PWM_EN.
- leds  out  N_LEDS  registered LED drive, active-high.
- step  out  1  one-clock pulse, registered, coincident with each pattern advance.

## Operation
- **Reset:** asserting `reset` clears everything immediately, including mid-pattern.
  - `cnt`=0, `pos`=0, `up`=1, `phase`=0, `mode_q`=00.
  - Outputs: `leds`=0, `step`=0.
- **Prescaler:** `cnt` has width max(1,$clog2(TICK_DIV)) and counts only while `en`=1.
  - `tick` fires when `cnt`==TICK_DIV-1; `cnt` then wraps to 0.
  - With TICK_DIV=1, `tick` fires every enabled cycle.
- **Mode change:** when `mode` != `mode_q` and `en`=1:
  - `mode_q` <= `mode`, `cnt` <= 0, `pos` <= 0, `up` <= 1, `phase` <= 0.
  - Any coincident `tick` is discarded and `step` stays 0.
- **On tick, by `mode_q`:**
  - WALK: `pos` <= `pos`±1 modulo N_LEDS (+ when `dir`=0).
  - BOUNCE: ignores `dir`. At `pos`==N_LEDS-1 with `up`=1: `up` <= 0, `pos` <= N_LEDS-2. At `pos`==0 with `up`=0: `up` <= 1, `pos` <= 1. Otherwise `pos` moves one step toward the current direction. End LEDs never dwell twice.
  - FILL: `pos` <= `pos`+1 modulo N_LEDS; `dir` does not affect `pos`.
  - BLINK: `phase` <= ~`phase`.
- **Pattern decode `pat` (from next-state values):**
  - WALK/BOUNCE: one-hot at bit `pos`.
  - FILL, `dir`=0: bits [pos:0] set.
  - FILL, `dir`=1: bits [N_LEDS-1 : N_LEDS-1-pos] set.
  - BLINK: all ones if `phase`=1, else all zeros.
- **Output register:**
  - `en`=1: `leds` <= `pat`, `step` <= accepted `tick`.
  - `en`=0: `leds` <= 0, `step` <= 0; `cnt`, `pos`, `up`, `phase` and `mode_q` hold. Re-enabling resumes from the same point.
- `dir` changing mid-WALK takes effect at the next tick, with no reset of `pos`.

## Timing
- `leds` updates one clock after `en` rises. The first pattern after reset is bit 0 (WALK/BOUNCE/FILL-up) or all-off (BLINK).
- Pattern advance: `leds` and `step` change on the same edge, exactly TICK_DIV enabled clocks apart.
- A mode change shows the new mode's initial pattern one clock after `mode` changes. The first advance follows TICK_DIV enabled clocks later.
- `en` low→high or high→low affects `leds` on the next edge; prescaler progress is preserved.

## Configuration
- **LED_SEQ_PWM_EN defined:**
  - Adds the `duty` port and a free-running `pwm` counter of width PWM_BITS, advancing while `en`=1.
  - `leds` <= `pat` & {N_LEDS{(`pwm` < `duty`) | (&`duty`)}}.
  - `duty`=0 gives dark; all-ones gives fully on; other values give `duty`/2^PWM_BITS on-time.
  - `pwm` resets to 0.
- **Undefined:** no `duty` port, no `pwm` counter; `leds` <= `pat` unconditionally.

## Test plan
- N_LEDS=4, TICK_DIV=4, mode=00, dir=0, en=1 after reset → `leds` 0001, 0010, 0100, 1000, 0001, with `step` pulses every 4 clocks. With dir=1 → 0001, 1000, 0100.
- mode=01 → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. With N_LEDS=2 → 01, 10, 01.
- mode=10, dir=0 → 0001, 0011, 0111, 1111, 0001. With dir=1 → 1000, 1100, 1110, 1111.
- Mode change 00→11 on the same clock as a tick → no `step`, `leds`=0000 next clock, then 1111 after 4 clocks, then 0000.
- Running WALK at `leds`=0100: drop `en` for 10 clocks → `leds`=0000, `step`=0. Raise `en` → 0100 next clock, advancing to 1000 after the remaining prescaler count. Assert `reset` mid-count → `leds`=0000 asynchronously.
- LED_SEQ_PWM_EN, PWM_BITS=4: duty=4 → each lit LED high 4 of every 16 clocks; duty=0 → `leds` always 0; duty=15 → lit LEDs constantly high.
